// File: rtl/xbar_pkg.sv
// Shared crossbar types: command encoding and the agent FIFO controller states.
package xbar_pkg;

  typedef enum logic {
    XBAR_CMD_READ  = 1'b0,
    XBAR_CMD_WRITE = 1'b1
  } xbar_cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_ACK  = 2'd2,
    RD_ACK  = 2'd3
  } agent_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage plus wrap-bit read/write pointers; the data array itself is never reset.
module sync_fifo_mem #(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i && !full_o)
        r_wptr <= r_wptr + PTR_ONE;
      if (pop_i && !empty_o)
        r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      r_mem[r_wptr[AW-1:0]] <= wdata_i;
  end

  // Extra MSB distinguishes full (same slot, different lap) from empty.
  assign rdata_o = r_mem[r_rptr[AW-1:0]];
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign level_o = r_wptr - r_rptr;

endmodule

// File: rtl/agent_fifo.sv
// Crossbar agent that exposes a FIFO: writes push, reads pop, each closed by a one-cycle ack.
module agent_fifo
  import xbar_pkg::*;
#(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          req_i,
  input  logic          cmd_i,
  input  logic [DW-1:0] host_word_i,
  output logic          ack_o,
  output logic [DW-1:0] agent_word_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  agent_state_e r_state;
  agent_state_e w_state_nxt;
  xbar_cmd_e    w_cmd;
  logic         w_push;
  logic         w_pop;
  logic         w_ack;
  logic         w_full;
  logic         w_empty;

  assign w_cmd = xbar_cmd_e'(cmd_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Request and command are only looked at in IDLE; later states run to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          if (w_cmd == XBAR_CMD_WRITE && !w_full)
            w_state_nxt = WR_DATA;
          else if (w_cmd == XBAR_CMD_READ && !w_empty)
            w_state_nxt = RD_ACK;
        end
      end
      WR_DATA: begin
        w_push      = 1'b1;
        w_state_nxt = WR_ACK;
      end
      WR_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = IDLE;
      end
      RD_ACK: begin
        w_ack       = 1'b1;
        w_pop       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sync_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (w_push),
    .pop_i    (w_pop),
    .wdata_i  (host_word_i),
    .rdata_o  (agent_word_o),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .level_o  (level_o)
  );

  assign ack_o   = w_ack;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: tb/tb_agent_fifo.sv
// Self-checking bench for agent_fifo against a queue-based transaction model.
module tb_agent_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          req_i;
  logic          cmd_i;
  logic [DW-1:0] host_word_i;
  logic          ack_o;
  logic [DW-1:0] agent_word_o;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] model[$];

  agent_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .req_i        (req_i),
    .cmd_i        (cmd_i),
    .host_word_i  (host_word_i),
    .ack_o        (ack_o),
    .agent_word_o (agent_word_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .level_o      (level_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Starts in an IDLE cycle; ends in the IDLE cycle that follows the ack.
  task automatic write_txn(input logic [DW-1:0] d, input bit hold, input bit withdraw, input string tag);
    req_i = 1'b1; cmd_i = 1'b1; host_word_i = $urandom;
    tick();
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL %s wr_data_ack got=%b exp=0", tag, ack_o); end
    host_word_i = d;
    if (withdraw) begin req_i = 1'b0; cmd_i = 1'b0; end
    tick();
    model.push_back(d);
    total++;
    if (ack_o !== 1'b1) begin bad++; $display("FAIL %s wr_ack got=%b exp=1", tag, ack_o); end
    total++;
    if (level_o !== LW'(model.size())) begin bad++; $display("FAIL %s wr_level got=%0d exp=%0d", tag, level_o, model.size()); end
    total++;
    if (full_o !== (model.size() == DEPTH)) begin bad++; $display("FAIL %s wr_full got=%b exp=%b", tag, full_o, model.size() == DEPTH); end
    if (!hold) req_i = 1'b0;
    host_word_i = $urandom;
    tick();
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL %s wr_idle_ack got=%b exp=0", tag, ack_o); end
  endtask

  task automatic read_txn(input bit hold, input string tag);
    logic [DW-1:0] exp_d;
    exp_d = model[0];
    req_i = 1'b1; cmd_i = 1'b0;
    tick();
    total++;
    if (ack_o !== 1'b1) begin bad++; $display("FAIL %s rd_ack got=%b exp=1", tag, ack_o); end
    total++;
    if (agent_word_o !== exp_d) begin bad++; $display("FAIL %s rd_data got=%h exp=%h", tag, agent_word_o, exp_d); end
    if (!hold) req_i = 1'b0;
    tick();
    void'(model.pop_front());
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL %s rd_idle_ack got=%b exp=0", tag, ack_o); end
    total++;
    if (level_o !== LW'(model.size())) begin bad++; $display("FAIL %s rd_level got=%0d exp=%0d", tag, level_o, model.size()); end
    total++;
    if (empty_o !== (model.size() == 0)) begin bad++; $display("FAIL %s rd_empty got=%b exp=%b", tag, empty_o, model.size() == 0); end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; req_i = 1'b0; cmd_i = 1'b0; host_word_i = '0;
    repeat (3) tick();
    total++;
    if (empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty_o); end
    total++;
    if (level_o !== '0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level_o); end
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack_o); end
    total++;
    if (full_o !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full_o); end
    reset_ni = 1'b1;
    tick();
    req_i = 1'b1; cmd_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ack_o !== 1'b0) begin bad++; $display("FAIL empty_read_stall cyc%0d got=%b exp=0", i, ack_o); end
    end
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    write_txn(32'hDEADBEEF, 1'b0, 1'b0, "single_wr");
    read_txn(1'b0, "single_rd");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) write_txn(DW'(i), 1'b0, 1'b0, "fill_wr");
    total++;
    if (full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full_o); end
    req_i = 1'b1; cmd_i = 1'b1; host_word_i = 32'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ack_o !== 1'b0 || level_o !== LW'(DEPTH)) begin
        bad++; $display("FAIL full_write_stall cyc%0d ack=%b level=%0d exp ack=0 level=%0d", i, ack_o, level_o, DEPTH);
      end
    end
    total++;
    if (model[0] !== 32'h1) begin bad++; $display("FAIL fill_head got=%h exp=1", model[0]); end
    read_txn(1'b0, "fill_rd");
    write_txn(32'h9, 1'b0, 1'b0, "fill_pending_wr");
    while (model.size() != 0) read_txn(1'b0, "fill_drain");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) write_txn($urandom, 1'b0, 1'b0, "wrap_fill");
    for (int i = 0; i < 8; i++) read_txn(1'b0, "wrap_drain");
    for (int i = 0; i < 4; i++) write_txn(32'hA0 + DW'(i), 1'b0, 1'b0, "wrap_wr");
    for (int i = 0; i < 4; i++) read_txn(1'b0, "wrap_rd");
    total++;
    if (level_o !== '0) begin bad++; $display("FAIL wrap_level got=%0d exp=0", level_o); end
  endtask

  task automatic test_withdraw();
    write_txn($urandom, 1'b0, 1'b1, "withdraw_wr");
    read_txn(1'b0, "withdraw_rd");
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 0; i < 4; i++) write_txn($urandom, 1'b1, 1'b0, "b2b_wr");
    total++;
    if (cyc - start !== 12) begin bad++; $display("FAIL b2b_wr_cycles got=%0d exp=12", cyc - start); end
    start = cyc;
    for (int i = 0; i < 4; i++) read_txn(1'b1, "b2b_rd");
    total++;
    if (cyc - start !== 8) begin bad++; $display("FAIL b2b_rd_cycles got=%0d exp=8", cyc - start); end
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit is_wr;
    for (int n = 0; n < 80; n++) begin
      is_wr = ($urandom_range(0, 1) == 1);
      if ((is_wr && model.size() == DEPTH) || (!is_wr && model.size() == 0)) begin
        req_i = 1'b1; cmd_i = is_wr;
        for (int i = 0; i < 2; i++) begin
          tick();
          total++;
          if (ack_o !== 1'b0) begin bad++; $display("FAIL rand_stall op%0d got=%b exp=0", n, ack_o); end
        end
        req_i = 1'b0;
        tick();
      end else if (is_wr) begin
        write_txn($urandom, $urandom_range(0, 1) == 1, 1'b0, "rand_wr");
      end else begin
        read_txn($urandom_range(0, 1) == 1, "rand_rd");
      end
    end
    req_i = 1'b0;
    tick();
    while (model.size() != 0) read_txn(1'b0, "rand_drain");
  endtask

  task automatic test_reset_mid_read();
    write_txn($urandom, 1'b0, 1'b0, "rstrd_wr");
    write_txn($urandom, 1'b0, 1'b0, "rstrd_wr");
    req_i = 1'b1; cmd_i = 1'b0;
    tick();
    total++;
    if (ack_o !== 1'b1) begin bad++; $display("FAIL rstrd_ack_before got=%b exp=1", ack_o); end
    #2 reset_ni = 1'b0;
    req_i = 1'b0;
    #1;
    model.delete();
    total++;
    if (ack_o !== 1'b0 || level_o !== '0 || empty_o !== 1'b1) begin
      bad++; $display("FAIL rstrd_async ack=%b level=%0d empty=%b exp 0/0/1", ack_o, level_o, empty_o);
    end
    tick();
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ack_o !== 1'b0 || level_o !== '0 || empty_o !== 1'b1) begin
        bad++; $display("FAIL rstrd_after cyc%0d ack=%b level=%0d empty=%b exp 0/0/1", i, ack_o, level_o, empty_o);
      end
    end
    write_txn(32'h5A5A_1234, 1'b0, 1'b0, "rstrd_post_wr");
    read_txn(1'b0, "rstrd_post_rd");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_withdraw();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
